// File: rtl/skew_tx_pkg.sv
// Shared types and constants for the skew stream transmitter.
//   state_e           : controller states (IDLE, RUN, DRAIN)
//   ST_*              : bit positions inside statuses_o
//   STATUS_W / CNT_W  : widths of statuses_o and pair_cnt_o
package skew_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int unsigned ST_CLAMP = 0;
    localparam int unsigned ST_RUN   = 1;
    localparam int unsigned ST_DRAIN = 2;
    localparam int unsigned ST_DROP  = 3;

    localparam int unsigned STATUS_W = 8;
    localparam int unsigned CNT_W    = 16;

endpackage

// File: rtl/skew_delay_line.sv
// Programmable delay line for the 2d stream.
// A circular buffer of {vld, data} entries is written once per active cycle.
// The entry written 'delay' cycles earlier is read and registered.
// delay = 0 bypasses the buffer, so the output lags the input by the register stage only.
//   clk, aresetn      : clock, asynchronous active-low reset
//   flush             : clear all valid bits, pointer and output (controller idle)
//   active            : shift enable (controller running or draining)
//   delay             : skew in cycles, 0..DEPTH
//   wr_vld / wr_data  : entry written this cycle
//   rd_vld / rd_data  : registered delayed entry; rd_data = DEFAULT_ELEMENT when !rd_vld
module skew_delay_line
    import skew_tx_pkg::*;
#(
    parameter int unsigned           WIDTH           = 32,
    parameter int unsigned           DEPTH           = 16,
    parameter logic [WIDTH-1:0]      DEFAULT_ELEMENT = '0
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         flush,
    input  logic                         active,
    input  logic [$clog2(DEPTH+1)-1:0]   delay,
    input  logic                         wr_vld,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         rd_vld,
    output logic [WIDTH-1:0]             rd_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW = $clog2(DEPTH+1);
    localparam logic [DW:0] DEPTH_X = (DW+1)'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] mem_vld_q;
    logic [PW-1:0]    wp_q, wp_d;
    logic [DW:0]      wp_ext, delay_ext, rd_sum;
    logic [PW-1:0]    rd_idx;
    logic             sel_vld;
    logic [WIDTH-1:0] sel_data;
    logic             rd_vld_q;
    logic [WIDTH-1:0] rd_data_q;

    always_comb begin
        wp_ext    = (DW+1)'(wp_q);
        delay_ext = {1'b0, delay};
        // DEPTH need not be a power of two, so the modulo is an explicit wrap.
        if (wp_ext >= delay_ext) begin
            rd_sum = wp_ext - delay_ext;
        end else begin
            rd_sum = wp_ext + DEPTH_X - delay_ext;
        end
        rd_idx = rd_sum[PW-1:0];
        wp_d   = (wp_q == LAST_IDX) ? '0 : wp_q + PW'(1);

        // delay == DEPTH reads slot wp before it is overwritten: exactly DEPTH cycles old.
        if (delay == '0) begin
            sel_vld  = wr_vld;
            sel_data = wr_data;
        end else begin
            sel_vld  = mem_vld_q[rd_idx];
            sel_data = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wp_q      <= '0;
            mem_vld_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= DEFAULT_ELEMENT;
        end else if (flush) begin
            // Stale entries from an earlier run must never resurface.
            wp_q      <= '0;
            mem_vld_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= DEFAULT_ELEMENT;
        end else if (active) begin
            wp_q              <= wp_d;
            mem_vld_q[wp_q]   <= wr_vld;
            rd_vld_q          <= sel_vld;
            rd_data_q         <= sel_vld ? sel_data : DEFAULT_ELEMENT;
        end
    end

    // Payload storage needs no reset: it is qualified by mem_vld_q.
    always_ff @(posedge clk) begin
        if (active && !flush) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    assign rd_vld  = rd_vld_q;
    assign rd_data = rd_data_q;

endmodule

// File: rtl/skew_stream_tx.sv
// Skewed two-stream transmitter. Accepts {1st, 2d} pairs on a valid/ready handshake and
// re-emits them as two valid-only streams, the 2d stream lagging by a programmable delay.
// Optional feature macro: SKEW_TX_PAIR_CNT_EN (enables the pair_cnt_o counter).
//   clk, aresetn             : clock, asynchronous active-low reset
//   enable_i                 : start (1) / stop-and-drain (0) request
//   delay_i                  : skew in cycles, latched on IDLE->RUN, clamped to DEPTH_FIFO
//   data_1st_i, data_2d_i    : input pair
//   vld_i / rdy_o            : pair handshake
//   data_1st_o, vld_1st_o    : 1st stream
//   data_2d_o, vld_2d_o      : delayed 2d stream
//   statuses_o               : {4'b0, DROP, DRAIN, RUN, DELAY_CLAMP}
//   pair_cnt_o               : count of emitted 2d elements (0 when feature disabled)
module skew_stream_tx
    import skew_tx_pkg::*;
#(
    parameter int unsigned           WIDTH_FIFO          = 32,
    parameter int unsigned           DEPTH_FIFO          = 16,
    parameter logic [WIDTH_FIFO-1:0] DEFAULT_ELEMENT_1ST = '0,
    parameter logic [WIDTH_FIFO-1:0] DEFAULT_ELEMENT_2D  = '0
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic                              enable_i,
    input  logic [$clog2(DEPTH_FIFO+1)-1:0]   delay_i,
    input  logic [WIDTH_FIFO-1:0]             data_1st_i,
    input  logic [WIDTH_FIFO-1:0]             data_2d_i,
    input  logic                              vld_i,
    output logic                              rdy_o,
    output logic [WIDTH_FIFO-1:0]             data_1st_o,
    output logic                              vld_1st_o,
    output logic [WIDTH_FIFO-1:0]             data_2d_o,
    output logic                              vld_2d_o,
    output logic [STATUS_W-1:0]               statuses_o,
    output logic [CNT_W-1:0]                  pair_cnt_o
);

    localparam int unsigned DW = $clog2(DEPTH_FIFO+1);
    localparam logic [DW-1:0] DEPTH_D = DW'(DEPTH_FIFO);
    localparam logic [DW-1:0] ONE_D   = DW'(1);

    state_e          state_q, state_d;
    logic [DW-1:0]   delay_q, delay_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            clamp_q, clamp_d;
    logic            drop_q, drop_d;
    logic            start;
    logic            accept;
    logic            dl_flush, dl_active;

    logic            vld_1st_q;
    logic [WIDTH_FIFO-1:0] data_1st_q;

    assign rdy_o  = (state_q == RUN);
    assign accept = vld_i && rdy_o;

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        drain_d = drain_q;
        clamp_d = clamp_q;
        drop_d  = drop_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    start   = 1'b1;
                    state_d = RUN;
                    clamp_d = (delay_i > DEPTH_D);
                    delay_d = (delay_i > DEPTH_D) ? DEPTH_D : delay_i;
                    drop_d  = 1'b0;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = DRAIN;
                    drain_d = delay_q;
                end
            end
            DRAIN: begin
                // Stay D cycles so the last accepted 2d element leaves the delay line.
                if (drain_q <= ONE_D) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - ONE_D;
                end
            end
            default: state_d = IDLE;
        endcase
        if (vld_i && !rdy_o) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            delay_q    <= '0;
            drain_q    <= '0;
            clamp_q    <= 1'b0;
            drop_q     <= 1'b0;
            vld_1st_q  <= 1'b0;
            data_1st_q <= DEFAULT_ELEMENT_1ST;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            drain_q    <= drain_d;
            clamp_q    <= clamp_d;
            drop_q     <= drop_d;
            vld_1st_q  <= accept;
            data_1st_q <= accept ? data_1st_i : DEFAULT_ELEMENT_1ST;
        end
    end

    assign dl_flush  = (state_q == IDLE);
    assign dl_active = (state_q != IDLE);

    skew_delay_line #(
        .WIDTH           (WIDTH_FIFO),
        .DEPTH           (DEPTH_FIFO),
        .DEFAULT_ELEMENT (DEFAULT_ELEMENT_2D)
    ) u_delay_line (
        .clk     (clk),
        .aresetn (aresetn),
        .flush   (dl_flush),
        .active  (dl_active),
        .delay   (delay_q),
        .wr_vld  (accept),
        .wr_data (data_2d_i),
        .rd_vld  (vld_2d_o),
        .rd_data (data_2d_o)
    );

    assign vld_1st_o  = vld_1st_q;
    assign data_1st_o = data_1st_q;

    always_comb begin
        statuses_o           = '0;
        statuses_o[ST_CLAMP] = clamp_q;
        statuses_o[ST_RUN]   = (state_q == RUN);
        statuses_o[ST_DRAIN] = (state_q == DRAIN);
        statuses_o[ST_DROP]  = drop_q;
    end

`ifdef SKEW_TX_PAIR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (vld_2d_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pair_cnt_o = cnt_q;
`else
    assign pair_cnt_o = '0;
`endif

endmodule
